dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_SIZE, default 384, is the data memory depth in 32-bit words.
REQ-002 Parameter STARVE_MAX, default 4, is the number of consecutive denied debug cycles before the debug port is forced through.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-005 cpu_req  in  1  MEM-stage access request (MemRead or MemWrite).
REQ-006 cpu_we  in  1  1 = write, 0 = read.
REQ-007 cpu_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  in  32  write data.
REQ-009 cpu_stall  out  1  request not served this cycle; pipeline holds MEM stage.
REQ-010 cpu_rdata  out  32  read return data; cpu_rvalid  out  1  rdata valid.
REQ-011 dbg_req, dbg_we  in  1 each; dbg_addr, dbg_wdata  in  32 each: debug/loader port, same meaning as the CPU port.
REQ-012 dbg_gnt  out  1  debug request accepted this cycle.
REQ-013 dbg_rdata  out  32; dbg_rvalid  out  1: debug read return.
REQ-014 mem_en  out  1; mem_we  out  1; mem_addr  out  30 (word); mem_wdata  out  32: single-port RAM command.
REQ-015 mem_rdata  in  32  RAM read data, valid one cycle after a read command.
REQ-016 oor_err  out  1  sticky flag, set by any out-of-range access.

Function
REQ-017 Arbitration SHALL be combinational per cycle: only one requester -> that requester wins; both -> CPU wins unless starve_cnt == STARVE_MAX, then debug wins.
REQ-018 The winner's command SHALL drive mem_en/mem_we/mem_addr (= addr[31:2])/mem_wdata in the same cycle; with no winner, mem_en = 0 and the other memory outputs = 0.
REQ-019 cpu_stall = cpu_req & ~(CPU wins); dbg_gnt = dbg_req & (debug wins).
REQ-020 starve_cnt (3 bits) SHALL increment when dbg_req = 1 and debug loses, saturating at STARVE_MAX, and SHALL clear when debug wins or dbg_req = 0.
REQ-021 Return-owner FSM states: RET_NONE, RET_CPU, RET_DBG; next state = RET_CPU / RET_DBG on a granted read by that port, else RET_NONE; it is updated every cycle.
REQ-022 In RET_CPU: cpu_rvalid = 1 and cpu_rdata = mem_rdata (or 0 if that read was out of range); likewise for RET_DBG; the idle port's rvalid = 0 and rdata = 0.
REQ-023 Read latency SHALL be exactly one cycle from grant to rvalid; writes produce no rvalid.
REQ-024 Out of range (addr[31:2] >= MEM_SIZE): mem_en = 0, writes dropped, reads granted and returned as 0 with rvalid = 1, oor_err set.
REQ-025 Back-to-back grants are allowed every cycle, including a write immediately after a read to the same address; the read returns pre-write data.
REQ-026 A stalled CPU request SHALL be re-evaluated every cycle with its current inputs; no request is latched.
REQ-027 oor_err SHALL clear only on reset.

Reset
REQ-028 While reset = 0: FSM = RET_NONE, starve_cnt = 0, oor_err = 0, cpu_rvalid = dbg_rvalid = 0, cpu_rdata = dbg_rdata = 0.
REQ-029 Reset asserted with a read in flight SHALL discard the return; no rvalid after release.
REQ-030 Combinational outputs during reset SHALL follow REQ-017..019 with starve_cnt = 0.

Verification
REQ-031 CPU read only, addr 0x10, RAM word 4 = 0xDEADBEEF -> mem_en = 1, mem_addr = 4, cpu_stall = 0; next cycle cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF.
REQ-032 CPU and debug both request for 6 cycles -> CPU granted cycles 1-4, debug granted cycle 5 with cpu_stall = 1, CPU granted cycle 6.
REQ-033 Debug write 0x12345678 to 0x20, then CPU read of 0x20 next cycle -> cpu_rdata = 0x12345678.
REQ-034 CPU read of 0x600 (word 384) -> mem_en = 0, next cycle cpu_rvalid = 1, cpu_rdata = 0, oor_err = 1 held until reset.
REQ-035 Debug read granted, reset pulsed low before the next edge -> dbg_rvalid stays 0, starve_cnt = 0.
REQ-036 CPU write then CPU read of the same address in consecutive cycles -> no stall, read returns the written data.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// =============================================================================
// dmem_arbiter_if : CPU, debug and single-port RAM signal bundle for dmem_arbiter
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;

  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        oor_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output oor_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  oor_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// =============================================================================
// dmem_arbiter : CPU/debug data-memory arbiter with debug starvation guard
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter #(
  parameter int unsigned MEM_SIZE   = 384,
  parameter int unsigned STARVE_MAX = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [29:0] MEM_LIMIT  = 30'(MEM_SIZE);
  localparam logic [2:0]  STARVE_CAP = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_CPU  = 2'd1,
    RET_DBG  = 2'd2
  } ret_state_e;

  ret_state_e  ret_q, ret_d;
  logic        ret_oor_q, ret_oor_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic        oor_err_q, oor_err_d;

  logic        cpu_win, dbg_win, any_win, win_we, win_oor;
  logic [29:0] win_addr;
  logic [31:0] win_wdata;

  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.cpu_addr[1:0], bus.dbg_addr[1:0]};

  // CPU has priority unless debug has been denied STARVE_MAX cycles in a row.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (bus.cpu_req && bus.dbg_req) begin
      if (starve_cnt_q == STARVE_CAP) dbg_win = 1'b1;
      else                            cpu_win = 1'b1;
    end else begin
      cpu_win = bus.cpu_req;
      dbg_win = bus.dbg_req;
    end
    any_win   = cpu_win | dbg_win;
    win_we    = dbg_win ? bus.dbg_we          : bus.cpu_we;
    win_addr  = dbg_win ? bus.dbg_addr[31:2]  : bus.cpu_addr[31:2];
    win_wdata = dbg_win ? bus.dbg_wdata       : bus.cpu_wdata;
    win_oor   = any_win && (win_addr >= MEM_LIMIT);
  end

  always_comb begin
    starve_cnt_d = 3'd0;
    if (bus.dbg_req && !dbg_win)
      starve_cnt_d = (starve_cnt_q >= STARVE_CAP) ? STARVE_CAP : starve_cnt_q + 3'd1;

    ret_d = RET_NONE;
    if (cpu_win && !bus.cpu_we)      ret_d = RET_CPU;
    else if (dbg_win && !bus.dbg_we) ret_d = RET_DBG;

    ret_oor_d = win_oor;
    oor_err_d = oor_err_q | win_oor;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_q        <= RET_NONE;
      ret_oor_q    <= 1'b0;
      starve_cnt_q <= 3'd0;
      oor_err_q    <= 1'b0;
    end else begin
      ret_q        <= ret_d;
      ret_oor_q    <= ret_oor_d;
      starve_cnt_q <= starve_cnt_d;
      oor_err_q    <= oor_err_d;
    end
  end

  // Out-of-range accesses never reach the RAM; their reads return zero.
  assign bus.mem_en    = any_win & ~win_oor;
  assign bus.mem_we    = bus.mem_en & win_we;
  assign bus.mem_addr  = bus.mem_en ? win_addr  : 30'd0;
  assign bus.mem_wdata = bus.mem_en ? win_wdata : 32'd0;

  assign bus.cpu_stall = bus.cpu_req & ~cpu_win;
  assign bus.dbg_gnt   = bus.dbg_req & dbg_win;

  assign bus.cpu_rvalid = (ret_q == RET_CPU);
  assign bus.dbg_rvalid = (ret_q == RET_DBG);
  assign bus.cpu_rdata  = (bus.cpu_rvalid && !ret_oor_q) ? bus.mem_rdata : 32'd0;
  assign bus.dbg_rdata  = (bus.dbg_rvalid && !ret_oor_q) ? bus.mem_rdata : 32'd0;

  assign bus.oor_err = oor_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// =============================================================================
// tb_dmem_arbiter : directed scoreboard bench for dmem_arbiter with a RAM model
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MEM_SIZE   (384),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single-port RAM with one-cycle read latency.
  logic [31:0] ram [0:511];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[8:0]] <= bus.mem_wdata;
      else            bus.mem_rdata          <= ram[bus.mem_addr[8:0]];
    end
  end

  typedef struct {
    int          port;   // 1 = cpu, 2 = debug
    logic [31:0] data;
  } ret_t;

  ret_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic dbg(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
  endtask

  task automatic expect_ret(input int port, input logic [31:0] data);
    ret_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advance one clock; a read granted last cycle must return now, nothing else may.
  task automatic next_cycle();
    ret_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk1 ("ret_cpu_rvalid", bus.cpu_rvalid, e.port == 1);
      chk32("ret_cpu_rdata",  bus.cpu_rdata,  (e.port == 1) ? e.data : 32'd0);
      chk1 ("ret_dbg_rvalid", bus.dbg_rvalid, e.port == 2);
      chk32("ret_dbg_rdata",  bus.dbg_rdata,  (e.port == 2) ? e.data : 32'd0);
    end else begin
      chk1("idle_cpu_rvalid", bus.cpu_rvalid, 1'b0);
      chk1("idle_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    dbg(1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    chk1 ("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk1 ("rst_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    chk32("rst_cpu_rdata",  bus.cpu_rdata,  32'd0);
    chk32("rst_dbg_rdata",  bus.dbg_rdata,  32'd0);
    chk1 ("rst_oor_err",    bus.oor_err,    1'b0);
    chk1 ("rst_mem_en",     bus.mem_en,     1'b0);

    // Arbitration stays combinational while reset is held.
    cpu(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk1 ("rst_comb_mem_en", bus.mem_en,    1'b1);
    chk32("rst_comb_addr",   {2'b00, bus.mem_addr}, 32'd4);
    chk1 ("rst_comb_stall",  bus.cpu_stall, 1'b0);
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();

    // Debug loader writes word 4.
    dbg(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    chk1 ("ldr_dbg_gnt", bus.dbg_gnt, 1'b1);
    chk1 ("ldr_mem_we",  bus.mem_we,  1'b1);
    chk32("ldr_addr",    {2'b00, bus.mem_addr}, 32'd4);
    next_cycle();

    // CPU read of word 4.
    dbg(1'b0, 1'b0, 32'h0, 32'h0);
    cpu(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk1 ("rd_mem_en", bus.mem_en,    1'b1);
    chk32("rd_addr",   {2'b00, bus.mem_addr}, 32'd4);
    chk1 ("rd_stall",  bus.cpu_stall, 1'b0);
    expect_ret(1, 32'hDEADBEEF);
    next_cycle();

    // Debug write then CPU read of the same address.
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    dbg(1'b1, 1'b1, 32'h20, 32'h12345678);
    #1;
    chk1("dw_dbg_gnt", bus.dbg_gnt, 1'b1);
    next_cycle();
    dbg(1'b0, 1'b0, 32'h0, 32'h0);
    cpu(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    chk1("dw_rd_stall", bus.cpu_stall, 1'b0);
    expect_ret(1, 32'h12345678);
    next_cycle();

    // CPU write then read, then read followed by overwrite of the same word.
    cpu(1'b1, 1'b1, 32'h40, 32'hA5A50001);
    #1;
    chk1("wr_stall", bus.cpu_stall, 1'b0);
    next_cycle();
    cpu(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    chk1("wr_rd_stall", bus.cpu_stall, 1'b0);
    expect_ret(1, 32'hA5A50001);
    next_cycle();
    cpu(1'b1, 1'b1, 32'h40, 32'hBBBB0002);
    #1;
    chk1("rw_stall", bus.cpu_stall, 1'b0);
    next_cycle();
    cpu(1'b1, 1'b0, 32'h42, 32'h0);
    #1;
    expect_ret(1, 32'hBBBB0002);
    next_cycle();

    // Six cycles of contention: debug forced through on the fifth.
    for (int k = 1; k <= 6; k++) begin
      cpu(1'b1, 1'b0, 32'h10, 32'h0);
      dbg(1'b1, 1'b0, 32'h20, 32'h0);
      #1;
      chk1("arb_cpu_stall", bus.cpu_stall, k == 5);
      chk1("arb_dbg_gnt",   bus.dbg_gnt,   k == 5);
      expect_ret((k == 5) ? 2 : 1, (k == 5) ? 32'h12345678 : 32'hDEADBEEF);
      next_cycle();
    end
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    dbg(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    // Out-of-range read at word 384.
    cpu(1'b1, 1'b0, 32'h600, 32'h0);
    #1;
    chk1("oor_mem_en",     bus.mem_en,    1'b0);
    chk1("oor_stall",      bus.cpu_stall, 1'b0);
    chk1("oor_err_before", bus.oor_err,   1'b0);
    expect_ret(1, 32'd0);
    next_cycle();
    chk1("oor_err_set", bus.oor_err, 1'b1);

    // Out-of-range debug write is granted but dropped.
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    dbg(1'b1, 1'b1, 32'h800, 32'hFFFFFFFF);
    #1;
    chk1("oorw_mem_en",  bus.mem_en,  1'b0);
    chk1("oorw_dbg_gnt", bus.dbg_gnt, 1'b1);
    next_cycle();

    // Last valid word 383.
    dbg(1'b0, 1'b0, 32'h0, 32'h0);
    cpu(1'b1, 1'b1, 32'h5FC, 32'hCAFE0383);
    #1;
    chk1 ("top_mem_en", bus.mem_en, 1'b1);
    chk32("top_addr",   {2'b00, bus.mem_addr}, 32'd383);
    next_cycle();
    cpu(1'b1, 1'b0, 32'h5FC, 32'h0);
    #1;
    expect_ret(1, 32'hCAFE0383);
    next_cycle();
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    chk1("oor_err_sticky", bus.oor_err, 1'b1);

    // Debug read in flight is discarded by reset.
    dbg(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    chk1("disc_dbg_gnt", bus.dbg_gnt, 1'b1);
    @(posedge clk);
    #1;
    dbg(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk1 ("disc_dbg_rvalid", bus.dbg_rvalid, 1'b0);
    chk32("disc_dbg_rdata",  bus.dbg_rdata,  32'd0);
    chk1 ("disc_oor_clear",  bus.oor_err,    1'b0);
    reset = 1'b1;
    next_cycle();

    // Reset mid-contention clears the starvation count.
    for (int k = 1; k <= 3; k++) begin
      cpu(1'b1, 1'b0, 32'h10, 32'h0);
      dbg(1'b1, 1'b0, 32'h20, 32'h0);
      #1;
      chk1("pre_stall", bus.cpu_stall, 1'b0);
      expect_ret(1, 32'hDEADBEEF);
      next_cycle();
    end
    #1;
    reset = 1'b0;
    #1;
    chk1("rst_mid_stall", bus.cpu_stall, 1'b0);
    reset = 1'b1;
    #1;
    chk1("post_rst_stall", bus.cpu_stall, 1'b0);
    expect_ret(1, 32'hDEADBEEF);
    next_cycle();
    for (int k = 5; k <= 8; k++) begin
      #1;
      chk1("starve_cpu_stall", bus.cpu_stall, k == 8);
      chk1("starve_dbg_gnt",   bus.dbg_gnt,   k == 8);
      expect_ret((k == 8) ? 2 : 1, (k == 8) ? 32'h12345678 : 32'hDEADBEEF);
      next_cycle();
    end
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    dbg(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
